// File: rtl/execute.sv
// ----------------------------------------------------------------------------
// execute: execute stage of the five-stage pipeline.
//
// Computes the ALU result for each instruction from decode and registers it,
// with the write-back and memory-control bits, into the execute/memory
// pipeline register. Single-cycle ops issue one per clock. MUL/DIVU/REMU run
// on a shared iterative unit (shift-add multiply, restoring divide) that takes
// exactly DataSize cycles, during which busy_o stalls decode.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   valid_i                   instruction present from decode
//   wreg_i, m2reg_i, wmem_i   write-back / memory control bits
//   aluop_i                   operation select (see aluop_e)
//   destination_i             destination register index
//   op1_i, op2_i              operands (op2_i doubles as store data)
//   valid_o                   pipeline register holds a real instruction
//   wreg_o, m2reg_o, wmem_o   registered control bits
//   destination_o             registered destination
//   aluresult_o               registered result / memory address
//   op2_o                     registered op2 (store data)
//   busy_o                    iterative unit active; decode must hold
// ----------------------------------------------------------------------------
module execute #(
    parameter int DataSize    = 32,
    parameter int BitsRegfile = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    input  logic                   wreg_i,
    input  logic                   m2reg_i,
    input  logic                   wmem_i,
    input  logic [3:0]             aluop_i,
    input  logic [BitsRegfile:0]   destination_i,
    input  logic [DataSize-1:0]    op1_i,
    input  logic [DataSize-1:0]    op2_i,
    output logic                   valid_o,
    output logic                   wreg_o,
    output logic                   m2reg_o,
    output logic                   wmem_o,
    output logic [BitsRegfile:0]   destination_o,
    output logic [DataSize-1:0]    aluresult_o,
    output logic [DataSize-1:0]    op2_o,
    output logic                   busy_o
);

    localparam int ShiftW = $clog2(DataSize);
    localparam int CountW = $clog2(DataSize) + 1;
    localparam logic [CountW-1:0] LastIter = CountW'(DataSize - 1);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIVU = 4'd11,
        ALU_REMU = 4'd12
    } aluop_e;

    typedef enum logic {
        IDLE,
        ITER
    } state_e;

    state_e              state;
    logic [CountW-1:0]   count;

    // Operation latched at accept; inputs are ignored while iterating.
    aluop_e              op_q;
    logic                wreg_q;
    logic                m2reg_q;
    logic                wmem_q;
    logic [BitsRegfile:0] dest_q;
    logic [DataSize-1:0] op2_q;

    // Shared iterative datapath.
    //   MUL : opa = multiplicand (shifts left), opb = multiplier (shifts right),
    //         acc = partial product.
    //   DIV : opa = divisor, opb = dividend shifting out / quotient shifting in,
    //         acc = partial remainder.
    logic [DataSize-1:0] opa;
    logic [DataSize-1:0] opb;
    logic [DataSize-1:0] acc;

    aluop_e              op;
    logic [ShiftW-1:0]   shamt;
    logic                is_multi;
    logic [DataSize-1:0] alu_result;

    assign op       = aluop_e'(aluop_i);
    assign shamt    = op2_i[ShiftW-1:0];
    assign is_multi = (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    assign busy_o   = (state == ITER);

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        alu_result = '0;
        case (op)
            ALU_ADD:  alu_result = op1_i + op2_i;
            ALU_SUB:  alu_result = op1_i - op2_i;
            ALU_AND:  alu_result = op1_i & op2_i;
            ALU_OR:   alu_result = op1_i | op2_i;
            ALU_XOR:  alu_result = op1_i ^ op2_i;
            ALU_SLL:  alu_result = op1_i << shamt;
            ALU_SRL:  alu_result = op1_i >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(op1_i) >>> shamt);
            ALU_SLT:  alu_result = {{(DataSize-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
            ALU_SLTU: alu_result = {{(DataSize-1){1'b0}}, op1_i < op2_i};
            default:  alu_result = '0;
        endcase
    end

    // One iteration of each algorithm, evaluated from the current registers.
    logic [DataSize-1:0] mul_acc_next;
    logic [DataSize:0]   rem_shift;
    logic                div_ge;
    logic [DataSize-1:0] rem_next;
    logic [DataSize-1:0] quo_next;

    assign mul_acc_next = acc + (opb[0] ? opa : '0);
    assign rem_shift    = {acc, opb[DataSize-1]};
    assign div_ge       = rem_shift >= {1'b0, opa};
    // The true difference is below the divisor, so the low DataSize bits are exact.
    // A zero divisor makes every step subtract nothing: quotient all ones and
    // remainder equal to the dividend, with no special case needed.
    assign rem_next     = div_ge ? rem_shift[DataSize-1:0] - opa : rem_shift[DataSize-1:0];
    assign quo_next     = {opb[DataSize-2:0], div_ge};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            count         <= '0;
            op_q          <= ALU_ADD;
            wreg_q        <= 1'b0;
            m2reg_q       <= 1'b0;
            wmem_q        <= 1'b0;
            dest_q        <= '0;
            op2_q         <= '0;
            opa           <= '0;
            opb           <= '0;
            acc           <= '0;
            valid_o       <= 1'b0;
            wreg_o        <= 1'b0;
            m2reg_o       <= 1'b0;
            wmem_o        <= 1'b0;
            destination_o <= '0;
            aluresult_o   <= '0;
            op2_o         <= '0;
        end else begin
            // Bubble unless a result is issued below.
            valid_o       <= 1'b0;
            wreg_o        <= 1'b0;
            m2reg_o       <= 1'b0;
            wmem_o        <= 1'b0;
            destination_o <= '0;
            aluresult_o   <= '0;
            op2_o         <= '0;

            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (is_multi) begin
                            state   <= ITER;
                            count   <= '0;
                            op_q    <= op;
                            wreg_q  <= wreg_i;
                            m2reg_q <= m2reg_i;
                            wmem_q  <= wmem_i;
                            dest_q  <= destination_i;
                            op2_q   <= op2_i;
                            acc     <= '0;
                            if (op == ALU_MUL) begin
                                opa <= op1_i;
                                opb <= op2_i;
                            end else begin
                                opa <= op2_i;
                                opb <= op1_i;
                            end
                        end else begin
                            valid_o       <= 1'b1;
                            wreg_o        <= wreg_i;
                            m2reg_o       <= m2reg_i;
                            wmem_o        <= wmem_i;
                            destination_o <= destination_i;
                            aluresult_o   <= alu_result;
                            op2_o         <= op2_i;
                        end
                    end
                end

                ITER: begin
                    count <= count + CountW'(1);
                    if (op_q == ALU_MUL) begin
                        acc <= mul_acc_next;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end else begin
                        acc <= rem_next;
                        opb <= quo_next;
                    end

                    // Fixed latency: the last iteration always issues the result.
                    if (count == LastIter) begin
                        state         <= IDLE;
                        valid_o       <= 1'b1;
                        wreg_o        <= wreg_q;
                        m2reg_o       <= m2reg_q;
                        wmem_o        <= wmem_q;
                        destination_o <= dest_q;
                        op2_o         <= op2_q;
                        case (op_q)
                            ALU_MUL:  aluresult_o <= mul_acc_next;
                            ALU_DIVU: aluresult_o <= quo_next;
                            default:  aluresult_o <= rem_next;
                        endcase
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute.sv
// ----------------------------------------------------------------------------
// tb_execute: directed self-checking bench for the execute stage
// (DataSize = 32). Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, well away from the next active edge.
// ----------------------------------------------------------------------------
module tb_execute;

    localparam int DW = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          wreg_i;
    logic          m2reg_i;
    logic          wmem_i;
    logic [3:0]    aluop_i;
    logic [4:0]    destination_i;
    logic [DW-1:0] op1_i;
    logic [DW-1:0] op2_i;
    logic          valid_o;
    logic          wreg_o;
    logic          m2reg_o;
    logic          wmem_o;
    logic [4:0]    destination_o;
    logic [DW-1:0] aluresult_o;
    logic [DW-1:0] op2_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .wreg_i        (wreg_i),
        .m2reg_i       (m2reg_i),
        .wmem_i        (wmem_i),
        .aluop_i       (aluop_i),
        .destination_i (destination_i),
        .op1_i         (op1_i),
        .op2_i         (op2_i),
        .valid_o       (valid_o),
        .wreg_o        (wreg_o),
        .m2reg_o       (m2reg_o),
        .wmem_o        (wmem_o),
        .destination_o (destination_o),
        .aluresult_o   (aluresult_o),
        .op2_o         (op2_o),
        .busy_o        (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic wr, input logic [4:0] dst);
        valid_i       = v;
        aluop_i       = op;
        op1_i         = a;
        op2_i         = b;
        wreg_i        = wr;
        m2reg_i       = 1'b0;
        wmem_i        = 1'b0;
        destination_i = dst;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".valid"}, 64'(valid_o), 64'd0);
        check({tag, ".ctrl"}, 64'({wreg_o, m2reg_o, wmem_o}), 64'd0);
        check({tag, ".dest"}, 64'(destination_o), 64'd0);
        check({tag, ".result"}, 64'(aluresult_o), 64'd0);
        check({tag, ".op2"}, 64'(op2_o), 64'd0);
    endtask

    // Accept a multicycle op, hold ADD 1+1 behind it, verify busy window,
    // the fixed-latency result, and that the held ADD issues one edge later.
    task automatic run_multi(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic [DW-1:0] exp);
        int busy_cycles;
        int early_valid;
        drive(1'b1, op, a, b, 1'b1, 5'd9);
        step();                                   // edge E: accept
        busy_cycles = 0;
        early_valid = 0;
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, 5'd7);
        for (int i = 0; i < DW; i++) begin        // samples after E .. E+DW-1
            if (busy_o) busy_cycles++;
            if (valid_o) early_valid++;
            if (i != DW - 1) step();
        end
        check({tag, ".busy_cycles"}, 64'(busy_cycles), 64'(DW));
        check({tag, ".valid_while_busy"}, 64'(early_valid), 64'd0);
        step();                                   // edge E+DW: result
        check({tag, ".busy_done"}, 64'(busy_o), 64'd0);
        check({tag, ".valid"}, 64'(valid_o), 64'd1);
        check({tag, ".result"}, 64'(aluresult_o), 64'(exp));
        check({tag, ".dest"}, 64'(destination_o), 64'd9);
        check({tag, ".wreg"}, 64'(wreg_o), 64'd1);
        step();                                   // edge E+DW+1: held ADD
        check({tag, ".held_add"}, 64'(aluresult_o), 64'd2);
        check({tag, ".held_dest"}, 64'(destination_o), 64'd7);
        drive(1'b0, OP_ADD, '0, '0, 1'b0, 5'd0);
    endtask

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[1]  = '{OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[2]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[3]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[4]  = '{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5]  = '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
        vecs[6]  = '{OP_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
        vecs[7]  = '{OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
        vecs[8]  = '{OP_SLL,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010};
        vecs[9]  = '{OP_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
        vecs[10] = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[11] = '{OP_SLL,  32'h0000_0003, 32'h0000_0020, 32'h0000_0003};
        vecs[12] = '{OP_SRA,  32'h4000_0000, 32'h0000_0002, 32'h1000_0000};

        rst_i = 1'b1;
        drive(1'b0, OP_ADD, '0, '0, 1'b0, 5'd0);
        step();
        step();
        check_bubble("reset");
        check("reset.busy", 64'(busy_o), 64'd0);
        rst_i = 1'b0;

        // ADD 5+7 -> 12, then a bubble clears everything.
        drive(1'b1, OP_ADD, 32'd5, 32'd7, 1'b1, 5'd3);
        step();
        check("add.result", 64'(aluresult_o), 64'd12);
        check("add.wreg", 64'(wreg_o), 64'd1);
        check("add.dest", 64'(destination_o), 64'd3);
        check("add.valid", 64'(valid_o), 64'd1);
        check("add.op2", 64'(op2_o), 64'd7);
        drive(1'b0, OP_ADD, 32'd5, 32'd7, 1'b1, 5'd3);
        step();
        check_bubble("bubble");

        // Back-to-back single-cycle ops, one per clock.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 5'(i + 1));
            step();
            check($sformatf("vec%0d.result", i), 64'(aluresult_o), 64'(vecs[i].exp));
            check($sformatf("vec%0d.valid", i), 64'(valid_o), 64'd1);
        end

        // Store: address = 0x100 + 0xCAFE, store data passes through.
        drive(1'b1, OP_ADD, 32'h100, 32'hCAFE, 1'b0, 5'd0);
        wmem_i  = 1'b1;
        m2reg_i = 1'b1;
        step();
        check("store.op2", 64'(op2_o), 64'hCAFE);
        check("store.wmem", 64'(wmem_o), 64'd1);
        check("store.m2reg", 64'(m2reg_o), 64'd1);
        check("store.addr", 64'(aluresult_o), 64'hCBFE);
        check("store.wreg", 64'(wreg_o), 64'd0);

        // Reserved aluop: result 0, control passes through.
        drive(1'b1, 4'd13, 32'h1234, 32'h55, 1'b1, 5'd17);
        step();
        check("op13.result", 64'(aluresult_o), 64'd0);
        check("op13.wreg", 64'(wreg_o), 64'd1);
        check("op13.valid", 64'(valid_o), 64'd1);
        check("op13.dest", 64'(destination_o), 64'd17);
        check("op13.op2", 64'(op2_o), 64'h55);

        // Multicycle ops; accept edge loads a bubble.
        drive(1'b1, OP_MUL, 32'h0001_0003, 32'h5, 1'b1, 5'd9);
        run_multi("mul", OP_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
        run_multi("mul_ones", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_multi("mul_zero", OP_MUL, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000);
        run_multi("divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_multi("remu", OP_REMU, 32'd100, 32'd7, 32'd2);
        run_multi("divu_zero", OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_multi("remu_zero", OP_REMU, 32'd9, 32'd0, 32'd9);
        run_multi("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        run_multi("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF);

        // Accept edge itself shows a bubble with busy asserted.
        drive(1'b1, OP_MUL, 32'd3, 32'd3, 1'b1, 5'd4);
        step();
        check("accept.valid", 64'(valid_o), 64'd0);
        check("accept.busy", 64'(busy_o), 64'd1);
        // Ten iterations, then a one-edge reset drops the operation.
        drive(1'b0, OP_ADD, '0, '0, 1'b0, 5'd0);
        for (int i = 0; i < 10; i++) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst.busy", 64'(busy_o), 64'd0);
        check_bubble("midrst");
        drive(1'b1, OP_ADD, 32'd3, 32'd4, 1'b1, 5'd2);
        step();
        check("postrst.result", 64'(aluresult_o), 64'd7);
        check("postrst.valid", 64'(valid_o), 64'd1);
        begin
            int late_valid;
            late_valid = 0;
            drive(1'b0, OP_ADD, '0, '0, 1'b0, 5'd0);
            for (int i = 0; i < 40; i++) begin
                step();
                if (valid_o || busy_o) late_valid++;
            end
            check("midrst.no_late_result", 64'(late_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute.md
# execute

Execute stage of the five-stage pipeline, sitting between decode and `memory`. It computes the ALU result for each instruction and registers it, together with the write-back and memory-control bits, into the execute/memory pipeline register that `memory` consumes. Single-cycle ops issue one per clock. MUL/DIVU/REMU run on an iterative shift-add / restoring-divide unit and assert `busy_o` to stall decode while they run.

## Interface
- `DataSize`, default 32: operand and result width. Must be a power of two, ≥ 8.
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; one clock; reset is synchronous and active-high
- `valid_i`  in  1  instruction present from decode
- `wreg_i`  in  1  instruction writes the register file
- `m2reg_i`  in  1  write-back selects memory data
- `wmem_i`  in  1  instruction stores to memory
- `aluop_i`  in  4  operation select
- `destination_i`  in  `BITS_REGFILE`+1  destination register index
- `op1_i`  in  DataSize  first operand
- `op2_i`  in  DataSize  second operand / store data
- `valid_o`  out  1  pipeline register holds a real instruction
- `wreg_o`, `m2reg_o`, `wmem_o`  out  1 each  registered control bits
- `destination_o`  out  `BITS_REGFILE`+1  registered destination
- `aluresult_o`  out  DataSize  registered result (memory address for loads/stores)
- `op2_o`  out  DataSize  registered `op2_i` (store data)
- `busy_o`  out  1  iterative unit active; decode must hold its inputs

## Operation
- aluop encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR (all modulo 2^DataSize).
  - 5 SLL, 6 SRL, 7 SRA; shift amount is `op2_i[log2(DataSize)-1:0]`.
  - 8 SLT (signed), 9 SLTU (unsigned): result 1 or 0, zero-extended.
  - 10 MUL: low DataSize bits of the unsigned product.
  - 11 DIVU, 12 REMU.
  - 13–15: result 0, control bits pass through.
- Divide by zero: DIVU gives all ones; REMU gives `op1_i`.
- FSM states:
  - IDLE → ITER when `valid_i`=1 and aluop ∈ {10,11,12}. The edge that moves to ITER latches operands, control bits and destination, and clears the counter.
  - ITER: one iteration per edge, counter increments. On the edge completing iteration DataSize, the pipeline register loads the result with `valid_o`=1, and the state returns to IDLE.
  - No other transitions.
- `busy_o` = (state == ITER), decoded from the registered state only.
- IDLE, `valid_i`=1, single-cycle op: the pipeline register loads the result and control bits with `valid_o`=1.
- IDLE, `valid_i`=0: bubble. The pipeline register loads all zeros (`valid_o`, `wreg_o`, `m2reg_o`, `wmem_o`, `destination_o`, `aluresult_o`, `op2_o` = 0).
- IDLE, multicycle op accepted: the pipeline register loads a bubble on that edge.
- ITER, any edge not completing the operation: the pipeline register loads a bubble.
- While in ITER, all inputs are ignored. Decode holds its next instruction, which is accepted on the first edge with `busy_o`=0.

## Timing
- Reset: on any edge with `rst_i`=1:
  - state = IDLE, counter = 0, `busy_o` = 0;
  - all outputs = 0.
  - This applies mid-iteration: the operation is dropped and no result is ever issued.
- Single-cycle ops: accepted at edge N, visible on outputs after edge N. Throughput is one instruction per clock.
- Multicycle ops:
  - accepted at edge E; result visible after edge E+DataSize;
  - `busy_o` high for exactly DataSize cycles (after E through before E+DataSize);
  - the held next instruction is accepted at edge E+DataSize+1.
  - Latency is fixed at DataSize cycles for every MUL/DIVU/REMU, including divide by zero and zero operands. No early termination.
- `valid_i` with a multicycle op while `busy_o`=1 is not a new accept.

## Test plan
- Reset then ADD `op1`=5, `op2`=7, `wreg`=1, dest=3 → after one edge: `aluresult_o`=12, `wreg_o`=1, `destination_o`=3, `valid_o`=1. Next cycle with `valid_i`=0 → all outputs 0.
- Back-to-back SUB 0−1, SRA 0x80000000>>4, SLT −1<1, SLTU 0xFFFFFFFF<1 (DataSize=32) → consecutive results FFFFFFFF, F8000000, 1, 0. Store with `wmem`=1, `op2`=0xCAFE → `op2_o`=0xCAFE, `wmem_o`=1.
- MUL 0x00010003 × 0x00000005 → `busy_o` high 32 cycles, `valid_o`=0 during them, then `aluresult_o`=0x0005000F. A held ADD 1+1 yields 2 exactly one edge after that.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU x/0 → FFFFFFFF; REMU 9/0 → 9. Each takes 32 cycles of `busy_o`.
- MUL started, then `rst_i` pulsed for one edge at iteration 10 → `busy_o`=0 and all outputs 0 after that edge. No result appears later. A new ADD is accepted on the next edge.
- aluop 13 with `wreg`=1 → `aluresult_o`=0, `wreg_o`=1, `valid_o`=1.
